// File: rtl/move_pkg.sv
`timescale 1ns/1ps
// Shared ids, charDir codes, request payload and FSM encoding for the move scheduler.
// Latency: n/a (declarations only).
// Backpressure: n/a.
package move_pkg;

    localparam logic CHAR_CAT   = 1'b0;
    localparam logic CHAR_MOUSE = 1'b1;

    // charDir is {axis,dir}; the scheduler passes it through without decoding.
    localparam logic [1:0] DIR_LEFT  = 2'b00;
    localparam logic [1:0] DIR_RIGHT = 2'b01;
    localparam logic [1:0] DIR_UP    = 2'b10;
    localparam logic [1:0] DIR_DOWN  = 2'b11;

    typedef struct packed {
        logic axis;
        logic dir;
    } mv_req_t;

    typedef enum logic [1:0] {
        ST_IDLE   = 2'd0,
        ST_ISSUE  = 2'd1,
        ST_WAIT   = 2'd2,
        ST_COMMIT = 2'd3
    } state_t;

endpackage

// File: rtl/move_cooldown.sv
`timescale 1ns/1ps
// Per-character request latch (latest wins) plus move cooldown counted in game ticks.
// Latency: a req is visible as eligible the cycle after it is sampled.
// Backpressure: none; requests are never refused, a newer one simply overwrites the older.
module move_cooldown
    import move_pkg::*;
#(
    parameter int COOLDOWN = 3,
    parameter int CD_W     = 4
) (
    input  logic    clk,
    input  logic    rst,
    input  logic    req,
    input  mv_req_t req_dat,
    input  logic    tick,
    input  logic    freeze,
    input  logic    grant,
    input  logic    commit,
    output logic    eligible,
    output mv_req_t stored
);

    logic            pending;
    logic [CD_W-1:0] cd_cnt;

    // Latch the newest request; a grant consumes it unless a req lands the same cycle.
    always_ff @(posedge clk) begin
        if (rst) begin
            pending <= 1'b0;
            stored  <= '0;
        end else if (req) begin
            pending <= 1'b1;
            stored  <= req_dat;
        end else if (grant) begin
            pending <= 1'b0;
        end
    end

    // Commit reloads the cooldown (beats a coincident tick); ticks count it down to 0.
    always_ff @(posedge clk) begin
        if (rst) begin
            cd_cnt <= '0;
        end else if (commit) begin
            cd_cnt <= CD_W'(COOLDOWN);
        end else if (tick && (cd_cnt != '0)) begin
            cd_cnt <= cd_cnt - 1'b1;
        end
    end

    assign eligible = pending && (cd_cnt == '0) && !freeze;

endmodule

// File: rtl/move_scheduler.sv
`timescale 1ns/1ps
// Round-robin shares one direction_converter between cat and mouse and commits one move at a time.
// Latency: move_valid pulses 2+CONV_LAT cycles after the grant cycle.
// Backpressure: one move in flight; further requests stay pending until IDLE and cooldown allow.
module move_scheduler
    import move_pkg::*;
#(
    parameter int CONV_LAT       = 1,
    parameter int CAT_COOLDOWN   = 3,
    parameter int MOUSE_COOLDOWN = 2,
    parameter int CD_W           = 4
) (
    input  logic       clk,
    input  logic       rst,
    input  logic       tick,
    input  logic       freeze,
    input  logic       cat_req,
    input  logic       cat_dir,
    input  logic       cat_axis,
    input  logic       mouse_req,
    input  logic       mouse_dir,
    input  logic       mouse_axis,
    output logic       conv_dir,
    output logic       conv_axis,
    input  logic [1:0] conv_char_dir,
    output logic       busy,
    output logic       move_valid,
    output logic       move_char,
    output logic [1:0] move_dir
);

    state_t     state;
    logic       last_grant;
    logic       cur_char;
    logic [1:0] lat_cnt;

    logic       cat_elig,  mouse_elig;
    mv_req_t    cat_stored, mouse_stored;
    logic       grant_vld;
    logic       grant_id;
    mv_req_t    grant_dat;

    logic       cat_grant,  mouse_grant;
    logic       cat_commit, mouse_commit;

    move_cooldown #(.COOLDOWN(CAT_COOLDOWN), .CD_W(CD_W)) u_cat (
        .clk      (clk),
        .rst      (rst),
        .req      (cat_req),
        .req_dat  ({cat_axis, cat_dir}),
        .tick     (tick),
        .freeze   (freeze),
        .grant    (cat_grant),
        .commit   (cat_commit),
        .eligible (cat_elig),
        .stored   (cat_stored)
    );

    move_cooldown #(.COOLDOWN(MOUSE_COOLDOWN), .CD_W(CD_W)) u_mouse (
        .clk      (clk),
        .rst      (rst),
        .req      (mouse_req),
        .req_dat  ({mouse_axis, mouse_dir}),
        .tick     (tick),
        .freeze   (freeze),
        .grant    (mouse_grant),
        .commit   (mouse_commit),
        .eligible (mouse_elig),
        .stored   (mouse_stored)
    );

    // Arbitrate in IDLE: a lone eligible character wins, a tie goes to whoever did not win last.
    always_comb begin
        grant_vld = 1'b0;
        grant_id  = CHAR_CAT;
        if (state == ST_IDLE) begin
            if (cat_elig && mouse_elig) begin
                grant_vld = 1'b1;
                grant_id  = ~last_grant;
            end else if (cat_elig) begin
                grant_vld = 1'b1;
                grant_id  = CHAR_CAT;
            end else if (mouse_elig) begin
                grant_vld = 1'b1;
                grant_id  = CHAR_MOUSE;
            end
        end
    end

    assign grant_dat    = (grant_id == CHAR_MOUSE) ? mouse_stored : cat_stored;
    assign cat_grant    = grant_vld && (grant_id == CHAR_CAT);
    assign mouse_grant  = grant_vld && (grant_id == CHAR_MOUSE);
    assign cat_commit   = (state == ST_COMMIT) && (cur_char == CHAR_CAT);
    assign mouse_commit = (state == ST_COMMIT) && (cur_char == CHAR_MOUSE);

    // Sequencer: issue to the converter, wait out its latency, then emit a one-cycle commit.
    always_ff @(posedge clk) begin
        if (rst) begin
            state      <= ST_IDLE;
            last_grant <= 1'b0;
            cur_char   <= 1'b0;
            lat_cnt    <= '0;
            conv_dir   <= 1'b0;
            conv_axis  <= 1'b0;
            busy       <= 1'b0;
            move_valid <= 1'b0;
            move_char  <= 1'b0;
            move_dir   <= 2'b00;
        end else begin
            move_valid <= 1'b0;
            case (state)
                ST_IDLE: begin
                    if (grant_vld) begin
                        state      <= ST_ISSUE;
                        busy       <= 1'b1;
                        cur_char   <= grant_id;
                        last_grant <= grant_id;
                        conv_dir   <= grant_dat.dir;
                        conv_axis  <= grant_dat.axis;
                    end
                end
                ST_ISSUE: begin
                    state   <= ST_WAIT;
                    lat_cnt <= 2'(CONV_LAT - 1);
                end
                ST_WAIT: begin
                    if (lat_cnt == '0) begin
                        state      <= ST_COMMIT;
                        move_dir   <= conv_char_dir;
                        move_char  <= cur_char;
                        move_valid <= 1'b1;
                    end else begin
                        lat_cnt <= lat_cnt - 1'b1;
                    end
                end
                ST_COMMIT: begin
                    state <= ST_IDLE;
                    busy  <= 1'b0;
                end
                default: begin
                    state <= ST_IDLE;
                    busy  <= 1'b0;
                end
            endcase
        end
    end

endmodule

// File: tb/tb_move_scheduler.sv
`timescale 1ns/1ps
// Bench for move_scheduler: directed scenarios with literal expectations, then random traffic.
// A transaction-level model predicts busy/commit/converter outputs every cycle.
// The converter is modelled as a pure CONV_LAT-cycle delay of {conv_axis,conv_dir}.
module tb_move_scheduler;
    import move_pkg::*;

    localparam int CONV_LAT = 1;
    localparam int CAT_CD   = 3;
    localparam int MOUSE_CD = 2;
    localparam int CD_W     = 4;

    logic       clk = 1'b0;
    logic       rst = 1'b1;
    logic       tick = 1'b0, freeze = 1'b0;
    logic       cat_req = 1'b0, cat_dir = 1'b0, cat_axis = 1'b0;
    logic       mouse_req = 1'b0, mouse_dir = 1'b0, mouse_axis = 1'b0;
    logic       conv_dir, conv_axis, busy, move_valid, move_char;
    logic [1:0] conv_char_dir, move_dir;

    int total  = 0;
    int passed = 0;
    bit model_on = 1'b0;

    always #5 clk = ~clk;

    move_scheduler #(
        .CONV_LAT(CONV_LAT), .CAT_COOLDOWN(CAT_CD), .MOUSE_COOLDOWN(MOUSE_CD), .CD_W(CD_W)
    ) dut (
        .clk(clk), .rst(rst), .tick(tick), .freeze(freeze),
        .cat_req(cat_req), .cat_dir(cat_dir), .cat_axis(cat_axis),
        .mouse_req(mouse_req), .mouse_dir(mouse_dir), .mouse_axis(mouse_axis),
        .conv_dir(conv_dir), .conv_axis(conv_axis), .conv_char_dir(conv_char_dir),
        .busy(busy), .move_valid(move_valid), .move_char(move_char), .move_dir(move_dir)
    );

    // Converter stand-in: fixed-latency delay line.
    logic [1:0] conv_pipe [CONV_LAT];
    always @(posedge clk) begin
        for (int i = CONV_LAT - 1; i > 0; i--) conv_pipe[i] <= conv_pipe[i-1];
        conv_pipe[0] <= {conv_axis, conv_dir};
    end
    assign conv_char_dir = conv_pipe[CONV_LAT-1];

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        total++;
        if (act !== exp)
            $display("FAIL %s actual=%0d required=%0d at %0t", name, act, exp, $time);
        else
            passed++;
    endtask

    // ---------------- behavioural model ----------------
    // m_rem: cycles still to spend on the in-flight move (0 = free to grant).
    int       m_rem;
    bit [1:0] m_pend, m_sdir, m_sax;
    int       m_cd [2];
    bit       m_last, m_fid;
    bit [1:0] m_fdir;
    bit       e_cdir, e_cax, e_mchar;
    bit [1:0] e_mdir;

    always @(posedge clk) begin : model
        int       rem;
        bit [1:0] pend, sdir, sax, el;
        int       cd [2];
        bit       last, fid, g, cdir, cax, mchar;
        bit [1:0] fdir, mdir;
        if (rst) begin
            m_rem <= 0; m_pend <= '0; m_sdir <= '0; m_sax <= '0;
            m_cd[0] <= 0; m_cd[1] <= 0; m_last <= 1'b0; m_fid <= 1'b0; m_fdir <= '0;
            e_cdir <= 1'b0; e_cax <= 1'b0; e_mchar <= 1'b0; e_mdir <= '0;
        end else begin
            rem = m_rem; pend = m_pend; sdir = m_sdir; sax = m_sax;
            cd[0] = m_cd[0]; cd[1] = m_cd[1]; last = m_last; fid = m_fid; fdir = m_fdir;
            cdir = e_cdir; cax = e_cax; mchar = e_mchar; mdir = e_mdir;
            for (int k = 0; k < 2; k++) begin
                if (m_rem == 1 && int'(m_fid) == k) cd[k] = (k == 0) ? CAT_CD : MOUSE_CD;
                else if (tick && cd[k] > 0)       cd[k] = cd[k] - 1;
            end
            if (m_rem == 0) begin
                for (int k = 0; k < 2; k++) el[k] = m_pend[k] && (m_cd[k] == 0) && !freeze;
                g = (el == 2'b11) ? !m_last : el[1];
                if (el != 2'b00) begin
                    pend[g] = 1'b0;
                    fid = g; last = g;
                    fdir = {m_sax[g], m_sdir[g]};
                    cdir = m_sdir[g]; cax = m_sax[g];
                    rem = 2 + CONV_LAT;
                end
            end else begin
                if (m_rem == 2) begin mchar = m_fid; mdir = m_fdir; end
                rem = m_rem - 1;
            end
            if (cat_req)   begin pend[0] = 1'b1; sdir[0] = cat_dir;   sax[0] = cat_axis;   end
            if (mouse_req) begin pend[1] = 1'b1; sdir[1] = mouse_dir; sax[1] = mouse_axis; end
            m_rem <= rem; m_pend <= pend; m_sdir <= sdir; m_sax <= sax;
            m_cd[0] <= cd[0]; m_cd[1] <= cd[1]; m_last <= last; m_fid <= fid; m_fdir <= fdir;
            e_cdir <= cdir; e_cax <= cax; e_mchar <= mchar; e_mdir <= mdir;
        end
    end

    // Compare every cycle on the falling edge.
    always @(negedge clk) begin
        if (model_on) begin
            chk("busy",       32'(busy),       32'(m_rem > 0));
            chk("move_valid", 32'(move_valid), 32'(m_rem == 1));
            chk("move_char",  32'(move_char),  32'(e_mchar));
            chk("move_dir",   32'(move_dir),   32'(e_mdir));
            chk("conv_dir",   32'(conv_dir),   32'(e_cdir));
            chk("conv_axis",  32'(conv_axis),  32'(e_cax));
        end
    end

    // ---------------- stimulus ----------------
    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic ticks(input int n);
        tick = 1'b1;
        repeat (n) step();
        tick = 1'b0;
    endtask

    task automatic wait_mv(input string name, input int max, output int n);
        n = 0;
        while (move_valid !== 1'b1 && n < max) begin
            step();
            n++;
        end
        chk(name, 32'(move_valid), 32'd1);
    endtask

    initial begin
        int n, extra;
        rst = 1'b1;
        step(); step();
        chk("rst_busy", 32'(busy), 0);
        chk("rst_mv",   32'(move_valid), 0);
        chk("rst_dir",  32'(move_dir), 0);
        chk("rst_conv", 32'({conv_axis, conv_dir}), 0);
        rst = 1'b0;
        model_on = 1'b1;

        // Single cat move, down.
        cat_req = 1'b1; cat_dir = 1'b1; cat_axis = 1'b1;
        step(); cat_req = 1'b0;
        chk("t1_idle_busy", 32'(busy), 0);
        step(); chk("t1_busy1", 32'(busy), 1); chk("t1_mv_early", 32'(move_valid), 0);
        step(); chk("t1_busy2", 32'(busy), 1);
        step(); chk("t1_mv", 32'(move_valid), 1);
        chk("t1_char", 32'(move_char), 0);
        chk("t1_dir", 32'(move_dir), 32'(DIR_DOWN));
        step(); chk("t1_mv_off", 32'(move_valid), 0); chk("t1_busy_off", 32'(busy), 0);

        // Simultaneous requests: mouse first (last grant was cat), then cat 4 cycles later.
        ticks(3);
        cat_req = 1'b1; cat_dir = 1'b0; cat_axis = 1'b0;
        mouse_req = 1'b1; mouse_dir = 1'b1; mouse_axis = 1'b0;
        step(); cat_req = 1'b0; mouse_req = 1'b0;
        wait_mv("t2_mv1", 8, n);
        chk("t2_char1", 32'(move_char), 1); chk("t2_dir1", 32'(move_dir), 32'(DIR_RIGHT));
        step();
        wait_mv("t2_mv2", 8, n);
        chk("t2_gap", n + 1, 4);
        chk("t2_char2", 32'(move_char), 0); chk("t2_dir2", 32'(move_dir), 32'(DIR_LEFT));

        // Re-request during the commit cycle with a coincident tick: three more ticks needed.
        tick = 1'b1; cat_req = 1'b1; cat_dir = 1'b1; cat_axis = 1'b0;
        step(); tick = 1'b0; cat_req = 1'b0;
        ticks(2); step(); step();
        chk("t3_blocked", 32'(busy), 0);
        ticks(1); step();
        chk("t3_granted", 32'(busy), 1);
        wait_mv("t3_mv", 8, n);
        chk("t3_dir", 32'(move_dir), 32'(DIR_RIGHT));

        // Two requests before a grant: latest wins, one commit.
        step();
        cat_req = 1'b1; cat_dir = 1'b0; cat_axis = 1'b0; step();
        cat_axis = 1'b1; step(); cat_req = 1'b0;
        ticks(3);
        wait_mv("t4_mv", 8, n);
        chk("t4_dir", 32'(move_dir), 32'(DIR_UP));
        extra = 0;
        repeat (10) begin step(); if (move_valid === 1'b1) extra++; end
        chk("t4_single", extra, 0);

        // Freeze during WAIT: the move still commits; the pending mouse waits for freeze to drop.
        ticks(3);
        cat_req = 1'b1; cat_dir = 1'b1; cat_axis = 1'b1;
        step(); cat_req = 1'b0;
        step(); step();
        freeze = 1'b1; mouse_req = 1'b1; mouse_dir = 1'b0; mouse_axis = 1'b1;
        step(); mouse_req = 1'b0;
        wait_mv("t5_mv", 6, n);
        chk("t5_char", 32'(move_char), 0);
        repeat (5) step();
        chk("t5_frozen", 32'(busy), 0);
        freeze = 1'b0;
        step();
        chk("t5_thaw_busy", 32'(busy), 1);
        wait_mv("t5_mv2", 8, n);
        chk("t5_char2", 32'(move_char), 1); chk("t5_dir2", 32'(move_dir), 32'(DIR_UP));

        // Reset in WAIT: outputs clear and the move is dropped.
        step(); ticks(3);
        cat_req = 1'b1; cat_dir = 1'b1; cat_axis = 1'b0;
        step(); cat_req = 1'b0;
        step(); step();
        rst = 1'b1; step(); rst = 1'b0;
        chk("t6_busy", 32'(busy), 0); chk("t6_mv", 32'(move_valid), 0);
        chk("t6_conv", 32'({conv_axis, conv_dir}), 0);
        chk("t6_char", 32'(move_char), 0); chk("t6_dir", 32'(move_dir), 0);
        extra = 0;
        repeat (8) begin step(); if (move_valid === 1'b1 || busy === 1'b1) extra++; end
        chk("t6_quiet", extra, 0);

        // Random traffic against the model.
        repeat (3000) begin
            rst        = ($urandom_range(0, 399) == 0);
            tick       = ($urandom_range(0, 2) == 0);
            freeze     = ($urandom_range(0, 7) == 0);
            cat_req    = ($urandom_range(0, 3) == 0);
            cat_dir    = 1'($urandom);
            cat_axis   = 1'($urandom);
            mouse_req  = ($urandom_range(0, 3) == 0);
            mouse_dir  = 1'($urandom);
            mouse_axis = 1'($urandom);
            step();
        end
        rst = 1'b0; tick = 1'b0; freeze = 1'b0; cat_req = 1'b0; mouse_req = 1'b0;
        repeat (10) step();
        model_on = 1'b0;
        $display("%0d/%0d checks passed", passed, total);
        $finish;
    end

endmodule
